// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared types and encodings for the multicycle controller
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op and instruction function fields to alu_control
module alu_decoder
    import controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    // Only R-type (op_5 = 1) may select subtract through funct7; I-type addi stays add
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing a multicycle RV32I subset datapath
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic                   funct7_5,
    input  logic                   zero,
    output logic                   pc_write,
    output logic                   adr_src,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             imm_src,
    output logic [2:0]             alu_control,
    output logic [STATE_WIDTH-1:0] state
);

    logic [STATE_WIDTH-1:0] state_q;
    logic [STATE_WIDTH-1:0] state_d;
    logic [STATE_WIDTH-1:0] dec_state;
    logic [1:0]             alu_op;
    logic                   pc_update;
    logic                   branch;
    logic                   ir_write_raw;
    logic                   mem_write_raw;
    logic                   reg_write_raw;

    // State register; reset loads FETCH so the first fetch happens on the first released edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= STATE_WIDTH'(S_FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unreachable encodings fall back to FETCH
    always_comb begin
        state_d = STATE_WIDTH'(S_FETCH);
        case (state_q)
            STATE_WIDTH'(S_FETCH): state_d = STATE_WIDTH'(S_DECODE);
            STATE_WIDTH'(S_DECODE): begin
                case (opcode)
                    OP_LW, OP_SW: state_d = STATE_WIDTH'(S_MEMADR);
                    OP_RTYPE:     state_d = STATE_WIDTH'(S_EXECR);
                    OP_ITYPE:     state_d = STATE_WIDTH'(S_EXECI);
                    OP_BEQ:       state_d = STATE_WIDTH'(S_BEQ);
                    OP_JAL:       state_d = STATE_WIDTH'(S_JAL);
                    default:      state_d = STATE_WIDTH'(S_FETCH);
                endcase
            end
            STATE_WIDTH'(S_MEMADR):  state_d = opcode[5] ? STATE_WIDTH'(S_MEMWRITE)
                                                         : STATE_WIDTH'(S_MEMREAD);
            STATE_WIDTH'(S_MEMREAD): state_d = STATE_WIDTH'(S_MEMWB);
            STATE_WIDTH'(S_EXECR),
            STATE_WIDTH'(S_EXECI),
            STATE_WIDTH'(S_JAL):     state_d = STATE_WIDTH'(S_ALUWB);
            default:                 state_d = STATE_WIDTH'(S_FETCH);
        endcase
    end

    // During reset the selects show FETCH values while the enables are gated off below
    assign dec_state = reset_n ? state_q : STATE_WIDTH'(S_FETCH);

    // Moore output decode of the (reset-adjusted) current state
    always_comb begin
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_OP_ADD;
        case (dec_state)
            STATE_WIDTH'(S_FETCH): begin
                ir_write_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                pc_update    = 1'b1;
            end
            STATE_WIDTH'(S_DECODE): begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            STATE_WIDTH'(S_MEMADR): begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            STATE_WIDTH'(S_MEMREAD): adr_src = 1'b1;
            STATE_WIDTH'(S_MEMWB): begin
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
            end
            STATE_WIDTH'(S_MEMWRITE): begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            STATE_WIDTH'(S_EXECR): begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_FUNCT;
            end
            STATE_WIDTH'(S_EXECI): begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            STATE_WIDTH'(S_ALUWB): reg_write_raw = 1'b1;
            STATE_WIDTH'(S_BEQ): begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
            end
            STATE_WIDTH'(S_JAL): begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the live opcode in every state
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    assign pc_write  = reset_n & (pc_update | (branch & zero));
    assign ir_write  = reset_n & ir_write_raw;
    assign mem_write = reset_n & mem_write_raw;
    assign reg_write = reset_n & reg_write_raw;
    assign state     = state_q;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_5        (opcode[5]),
        .funct7_5    (funct7_5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        string       name;
        logic [19:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] opcode = RT;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_controller #(.STATE_WIDTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .state       (state)
    );

    always #5 clk = ~clk;

    // en = {pc_write, ir_write, mem_write, reg_write, adr_src}
    task automatic cyc(input string name, input logic rn, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic z,
                       input logic [3:0] st, input logic [4:0] en, input logic [1:0] rs,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] imm,
                       input logic [2:0] alu);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n  = rn;
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        zero     = z;
        e.name = name;
        e.vec  = {st, en, rs, a, b, imm, alu};
        exp_q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [19:0] act;
            e = exp_q.pop_front();
            act = {state, pc_write, ir_write, mem_write, reg_write, adr_src,
                   result_src, alu_src_a, alu_src_b, imm_src, alu_control};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s: got st=%0d en=%b rs=%b a=%b b=%b imm=%b alu=%b, expected st=%0d en=%b rs=%b a=%b b=%b imm=%b alu=%b",
                         e.name, act[19:16], act[15:11], act[10:9], act[8:7], act[6:5], act[4:3], act[2:0],
                         e.vec[19:16], e.vec[15:11], e.vec[10:9], e.vec[8:7], e.vec[6:5], e.vec[4:3], e.vec[2:0]);
            end
        end
    end

    initial begin
        // reset held with R-type opcode
        for (int i = 0; i < 3; i++)
            cyc("reset", 0, RT, 3'b000, 1, 0, 4'd0, 5'b00000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        // R-type sub
        cyc("r_sub_fetch",  1, RT, 3'b000, 1, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("r_sub_decode", 1, RT, 3'b000, 1, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);
        cyc("r_sub_exec",   1, RT, 3'b000, 1, 0, 4'd6, 5'b00000, 2'd0, 2'd2, 2'd0, 2'd0, 3'b001);
        cyc("r_sub_wb",     1, RT, 3'b000, 1, 0, 4'd8, 5'b00010, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        // R-type and
        cyc("r_and_fetch",  1, RT, 3'b111, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("r_and_decode", 1, RT, 3'b111, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);
        cyc("r_and_exec",   1, RT, 3'b111, 0, 0, 4'd6, 5'b00000, 2'd0, 2'd2, 2'd0, 2'd0, 3'b010);
        cyc("r_and_wb",     1, RT, 3'b111, 0, 0, 4'd8, 5'b00010, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        // R-type or, then slt
        cyc("r_or_fetch",   1, RT, 3'b110, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("r_or_decode",  1, RT, 3'b110, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);
        cyc("r_or_exec",    1, RT, 3'b110, 0, 0, 4'd6, 5'b00000, 2'd0, 2'd2, 2'd0, 2'd0, 3'b011);
        cyc("r_or_wb",      1, RT, 3'b110, 0, 0, 4'd8, 5'b00010, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        // I-type with funct7_5 set stays add, then slti
        cyc("i_add_fetch",  1, IT, 3'b000, 1, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("i_add_decode", 1, IT, 3'b000, 1, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);
        cyc("i_add_exec",   1, IT, 3'b000, 1, 0, 4'd7, 5'b00000, 2'd0, 2'd2, 2'd1, 2'd0, 3'b000);
        cyc("i_add_wb",     1, IT, 3'b000, 1, 0, 4'd8, 5'b00010, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        cyc("i_slt_fetch",  1, IT, 3'b010, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("i_slt_decode", 1, IT, 3'b010, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);
        cyc("i_slt_exec",   1, IT, 3'b010, 0, 0, 4'd7, 5'b00000, 2'd0, 2'd2, 2'd1, 2'd0, 3'b101);
        cyc("i_slt_wb",     1, IT, 3'b010, 0, 0, 4'd8, 5'b00010, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        // lw
        cyc("lw_fetch",     1, LW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("lw_decode",    1, LW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);
        cyc("lw_memadr",    1, LW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'd0, 2'd2, 2'd1, 2'd0, 3'b000);
        cyc("lw_memread",   1, LW, 3'b010, 0, 0, 4'd3, 5'b00001, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        cyc("lw_memwb",     1, LW, 3'b010, 0, 0, 4'd4, 5'b00010, 2'd1, 2'd0, 2'd0, 2'd0, 3'b000);
        // sw
        cyc("sw_fetch",     1, SW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd1, 3'b000);
        cyc("sw_decode",    1, SW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd1, 3'b000);
        cyc("sw_memadr",    1, SW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'd0, 2'd2, 2'd1, 2'd1, 3'b000);
        cyc("sw_memwrite",  1, SW, 3'b010, 0, 0, 4'd5, 5'b00101, 2'd0, 2'd0, 2'd0, 2'd1, 3'b000);
        // beq taken, zero high in non-BEQ states must not reach pc_write in DECODE
        cyc("beq_t_fetch",  1, BQ, 3'b000, 0, 1, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd2, 3'b000);
        cyc("beq_t_decode", 1, BQ, 3'b000, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd2, 3'b000);
        cyc("beq_t_beq",    1, BQ, 3'b000, 0, 1, 4'd9, 5'b10000, 2'd0, 2'd2, 2'd0, 2'd2, 3'b001);
        // beq not taken
        cyc("beq_n_fetch",  1, BQ, 3'b000, 0, 1, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd2, 3'b000);
        cyc("beq_n_decode", 1, BQ, 3'b000, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd2, 3'b000);
        cyc("beq_n_beq",    1, BQ, 3'b000, 0, 0, 4'd9, 5'b00000, 2'd0, 2'd2, 2'd0, 2'd2, 3'b001);
        // unsupported opcode is a two-cycle NOP
        cyc("bad_fetch",    1, BAD, 3'b000, 0, 1, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("bad_decode",   1, BAD, 3'b000, 0, 1, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);
        // jal
        cyc("jal_fetch",    1, JL, 3'b000, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd3, 3'b000);
        cyc("jal_decode",   1, JL, 3'b000, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd3, 3'b000);
        cyc("jal_jal",      1, JL, 3'b000, 0, 0, 4'd10, 5'b10000, 2'd0, 2'd1, 2'd2, 2'd3, 3'b000);
        cyc("jal_aluwb",    1, JL, 3'b000, 0, 0, 4'd8, 5'b00010, 2'd0, 2'd0, 2'd0, 2'd3, 3'b000);
        // sw abandoned by reset in MEMWRITE: no write, FETCH-value selects
        cyc("swr_fetch",    1, SW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd1, 3'b000);
        cyc("swr_decode",   1, SW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd1, 3'b000);
        cyc("swr_memadr",   1, SW, 3'b010, 0, 0, 4'd2, 5'b00000, 2'd0, 2'd2, 2'd1, 2'd1, 3'b000);
        cyc("swr_rst_mw",   0, SW, 3'b010, 0, 0, 4'd5, 5'b00000, 2'd2, 2'd0, 2'd2, 2'd1, 3'b000);
        cyc("swr_rst_held", 0, SW, 3'b010, 0, 0, 4'd0, 5'b00000, 2'd2, 2'd0, 2'd2, 2'd1, 3'b000);
        cyc("swr_refetch",  1, LW, 3'b010, 0, 0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 2'd0, 3'b000);
        cyc("swr_redecode", 1, LW, 3'b010, 0, 0, 4'd1, 5'b00000, 2'd0, 2'd1, 2'd1, 2'd0, 3'b000);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Sequencing control unit that turns the processor's single-cycle datapath into a multicycle RV32I subset machine.
- Each instruction runs over 3–5 clock cycles through a Moore finite-state machine (FSM).
- Every cycle it drives the datapath's mux selects, write enables and ALU control.
- Sits beside the program counter, shared instruction/data memory, register file, extender and ALU. The decode inputs come from the instruction register, and `zero` comes from the ALU.

## Interface
Parameters:
- `STATE_WIDTH`, 4: width of the state register and the `state` debug port.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `opcode`  in  7  instr[6:0].
- `funct3`  in  3  instr[14:12].
- `funct7_5`  in  1  instr[30].
- `zero`  in  1  ALU result equals zero.
- `pc_write`  out  1  PC register load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- `mem_write`  out  1  data memory write enable.
- `ir_write`  out  1  instruction register and old-PC register load enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result select: 00 = ALU-out register, 01 = memory data register, 10 = live ALU result.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 register.
- `alu_src_b`  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `state`  out  STATE_WIDTH  current state, for debug only.

## Operation
States and encodings:
- FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10.
- Encodings 11–15 are unreachable. If ever entered, the next state is FETCH and all enables are 0.

Transitions:
- FETCH → DECODE.
- DECODE, selected by `opcode`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR.
  - 0110011 (R-type) → EXECR.
  - 0010011 (I-type ALU) → EXECI.
  - 1100011 (beq) → BEQ.
  - 1101111 (jal) → JAL.
  - Any other opcode → FETCH (treated as a NOP; no trap).
- MEMADR → MEMREAD when opcode[5] = 0, otherwise → MEMWRITE.
- MEMREAD → MEMWB.
- EXECR and EXECI → ALUWB.
- JAL → ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.

State outputs (any signal not listed is 0):
- FETCH: adr_src = 0, ir_write = 1, a = 00, b = 10, alu_op = 00, result_src = 10, pc_update = 1.
- DECODE: a = 01, b = 01, alu_op = 00 (computes the branch target).
- MEMADR: a = 10, b = 01, alu_op = 00.
- MEMREAD: adr_src = 1.
- MEMWB: result_src = 01, reg_write = 1.
- MEMWRITE: adr_src = 1, mem_write = 1.
- EXECR: a = 10, b = 00, alu_op = 10.
- EXECI: a = 10, b = 01, alu_op = 10.
- ALUWB: result_src = 00, reg_write = 1.
- BEQ: a = 10, b = 00, alu_op = 01, result_src = 00, branch = 1.
- JAL: a = 01, b = 10, alu_op = 00, result_src = 00, pc_update = 1.

Derived outputs:
- `pc_write = pc_update | (branch & zero)`.
- `imm_src` is decoded from `opcode` in every state:
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - Otherwise → 00.

ALU decoder:
- alu_op 00 → add; alu_op 01 → sub.
- alu_op 10, by `funct3`:
  - 000 → sub if opcode[5] & funct7_5, otherwise add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - Any other value → add.
- alu_op 11 → add.

## Timing
- State register updates on the rising edge of `clk`.
- All outputs are Moore functions of `state`, except `pc_write` (combinational in `zero` during BEQ) and `imm_src` (combinational in `opcode`).
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, unsupported opcode 2.

Reset:
- Any edge with `reset_n` = 0 loads FETCH.
- While `reset_n` = 0, these outputs are forced to 0: pc_write, ir_write, mem_write, reg_write.
- Mux selects and `alu_control` show FETCH values during reset.
- Reset asserted mid-instruction abandons it. No memory write or register write occurs on that edge.
- The first FETCH is performed on the first edge with `reset_n` = 1.

Other rules:
- `zero` is sampled only in BEQ. When it is 1, the edge leaving BEQ loads the PC from the ALU-out register, which holds the DECODE-cycle target.

## Structure
- Package `controller_pkg` holds:
  - the state enum;
  - opcode constants;
  - `alu_op` codes;
  - `alu_control` codes;
  - mux-select constants for `result_src`, `alu_src_a`, `alu_src_b` and `imm_src`.
- Sub-module `alu_decoder` is purely combinational: inputs alu_op, funct3, opcode[5], funct7_5; output alu_control.
- The top-level holds the FSM and the output decode.

## Test plan
- Reset: hold `reset_n` = 0 for 3 cycles with opcode = 0110011 → state 0, all four enables 0. Release → FETCH with ir_write = 1 and pc_write = 1, then DECODE.
- lw (0000011) → states 0, 1, 2, 3, 4, 0. reg_write = 1 only in state 4 with result_src = 01. imm_src = 00 throughout.
- sw (0100011) → states 0, 1, 2, 5, 0. mem_write = 1 only in state 5 with adr_src = 1. imm_src = 01.
- R-type sub (funct3 = 000, funct7_5 = 1) → alu_control = 001 in EXECR. With funct3 = 111 → 010. I-type with funct3 = 000 and funct7_5 = 1 → 000 (add).
- beq:
  - zero = 1 in BEQ → pc_write = 1, then FETCH.
  - zero = 0 → pc_write = 0.
  - zero toggling in any non-BEQ state has no effect on `pc_write`.
- Unsupported opcode 1111111 → 0, 1, 0 with no enables asserted in DECODE. jal → 0, 1, 10, 8 with pc_write = 1 in JAL and imm_src = 11.
